// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus of the data memory controller.
// Request side: req_valid/req_ready handshake with write, addr, wdata, width, sign_extend.
// Response side: single-cycle resp_valid pulse carrying resp_rdata and resp_fault.
interface data_memory_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0] req_width;
  logic req_sign_extend;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic resp_fault;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_width, req_sign_extend,
    input req_ready, resp_valid, resp_rdata, resp_fault
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, req_width, req_sign_extend,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: handshaked word-array data memory with split/trap of word-crossing accesses.
// Ports: clk, rst (async, active high), bus (slave side of data_memory_ctrl_if).
module data_memory_ctrl #(
  parameter int DEPTH_BITS = 10,
  parameter bit MISALIGN_MODE = 1'b0
) (
  input logic clk,
  input logic rst,
  data_memory_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, BEAT0_LAST, BEAT0_SPLIT, BEAT1, FAULT, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] idx, word;
  logic [1:0] off, width;
  logic write, sext, fault_q;
  logic [31:0] wdata, beat0_q, rdata_q, rd, wd, raw, fmt;
  logic [2:0] req_size;
  logic [32:0] last_byte;
  logic [63:0] wide_d;
  logic [7:0] wide_be;
  logic [3:0] be;
  logic open, acc, bad, split, beat, last;
  assign req_size = bus.req_width == 2'b00 ? 3'd1 : bus.req_width == 2'b01 ? 3'd2 : 3'd4;
  // 33-bit end address so accesses near 4 GiB cannot wrap past the range check
  assign last_byte = {1'b0, bus.req_addr} + {30'd0, req_size} - 33'd1;
  assign bad = &bus.req_width || last_byte >= (33'd4 << DEPTH_BITS) ||
               (MISALIGN_MODE && (bus.req_addr[1:0] & {bus.req_width[1], |bus.req_width}) != 2'd0);
  assign split = {1'b0, bus.req_addr[1:0]} + req_size > 3'd4;
  assign open = state == IDLE || state == RESP;
  assign acc = bus.req_valid && open;
  assign bus.req_ready = !rst && open;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  assign beat = state == BEAT0_LAST || state == BEAT0_SPLIT || state == BEAT1;
  assign last = state == BEAT0_LAST || state == BEAT1;
  assign word = state == BEAT1 ? idx + DEPTH_BITS'(1) : idx;
  assign rd = mem[word];
  // data and byte enables laid out over two words: low half is beat 0, high half is beat 1
  assign wide_d = {32'd0, wdata} << {off, 3'b000};
  assign wide_be = (width == 2'b00 ? 8'h01 : width == 2'b01 ? 8'h03 : 8'h0F) << off;
  assign be = state == BEAT1 ? wide_be[7:4] : wide_be[3:0];
  assign wd = state == BEAT1 ? wide_d[63:32] : wide_d[31:0];
  assign raw = 32'({rd, state == BEAT1 ? beat0_q : rd} >> {off, 3'b000});
  assign fmt = width == 2'b10 ? raw :
               width == 2'b01 ? {{16{sext & raw[15]}}, raw[15:0]} : {{24{sext & raw[7]}}, raw[7:0]};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RESP: state_nx = acc ? (bad ? FAULT : split ? BEAT0_SPLIT : BEAT0_LAST) : IDLE;
      BEAT0_SPLIT: state_nx = BEAT1;
      default: state_nx = RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      off <= '0;
      width <= '0;
      write <= 1'b0;
      sext <= 1'b0;
      wdata <= '0;
      beat0_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      fault_q <= state == FAULT;
      rdata_q <= last && !write ? fmt : 32'd0;
      if (state == BEAT0_SPLIT) beat0_q <= rd;
      if (acc) begin
        idx <= bus.req_addr[DEPTH_BITS+1:2];
        off <= bus.req_addr[1:0];
        width <= bus.req_width;
        write <= bus.req_write;
        sext <= bus.req_sign_extend;
        wdata <= bus.req_wdata;
      end
    end
  always_ff @(posedge clk)
    if (beat && write)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[word][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed stimulus checked against a byte-level model and literal expectations.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v1 = 1'b0;
  always #5 clk = ~clk;
  data_memory_ctrl_if b0 ();
  data_memory_ctrl_if b1 ();
  assign b1.req_valid = v1;
  assign b1.req_write = b0.req_write;
  assign b1.req_addr = b0.req_addr;
  assign b1.req_wdata = b0.req_wdata;
  assign b1.req_width = b0.req_width;
  assign b1.req_sign_extend = b0.req_sign_extend;
  data_memory_ctrl #(.DEPTH_BITS(10), .MISALIGN_MODE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  data_memory_ctrl #(.DEPTH_BITS(10), .MISALIGN_MODE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  int tests = 0;
  int fails = 0;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // byte-addressed reference memory and queue of pending responses for dut0
  typedef struct {
    int due;
    logic [31:0] rdata;
    logic fault;
  } exp_t;
  logic [7:0] mm [4096];
  exp_t q[$];
  int n = 0;
  function automatic void model(logic w, logic [31:0] a, logic [31:0] d, logic [1:0] wd, logic sx);
    int size;
    bit flt;
    exp_t e;
    logic [31:0] v;
    size = wd == 2'd0 ? 1 : wd == 2'd1 ? 2 : 4;
    flt = wd == 2'd3 || longint'(a) + size - 1 >= 4096;
    v = '0;
    if (!flt)
      for (int i = 0; i < size; i++)
        if (w) mm[a + i] = d[8*i +: 8];
        else v[8*i +: 8] = mm[a + i];
    if (!flt && !w && sx && v[8*size-1])
      for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
    e.fault = flt;
    e.rdata = w ? 32'd0 : v;
    e.due = n + (flt ? 2 : (a % 4) + size > 4 ? 3 : 2);
    q.push_back(e);
  endfunction
  always @(negedge clk) begin
    bit due_now;
    n++;
    if (rst) begin
      check("reset ready", b0.req_ready, 0);
      check("reset resp_valid", b0.resp_valid, 0);
      check("reset rdata", b0.resp_rdata, 0);
      check("reset fault", b0.resp_fault, 0);
      q.delete();
    end else begin
      due_now = 1'b0;
      if (q.size() != 0) due_now = q[0].due == n;
      check("ready", b0.req_ready, q.size() == 0 || due_now);
      if (due_now) begin
        check("resp_valid", b0.resp_valid, 1);
        check("resp_rdata", b0.resp_rdata, q[0].rdata);
        check("resp_fault", b0.resp_fault, q[0].fault);
        void'(q.pop_front());
      end else check("no resp_valid", b0.resp_valid, 0);
      if (b0.req_valid && b0.req_ready)
        model(b0.req_write, b0.req_addr, b0.req_wdata, b0.req_width, b0.req_sign_extend);
    end
  end
  task automatic xact(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] wd, input bit sx,
                      output logic [31:0] rd, output logic f, output int lat);
    int t;
    bit ok, got;
    @(posedge clk);
    #1;
    b0.req_write = w;
    b0.req_addr = a;
    b0.req_wdata = d;
    b0.req_width = wd;
    b0.req_sign_extend = sx;
    b0.req_valid = !sel;
    v1 = sel;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 20) begin
      @(negedge clk);
      t++;
      ok = sel ? b1.req_ready : b0.req_ready;
    end
    check("accept", ok, 1);
    @(posedge clk);
    #1;
    b0.req_valid = 1'b0;
    v1 = 1'b0;
    got = 1'b0;
    lat = 0;
    rd = '0;
    f = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? b1.resp_valid : b0.resp_valid) begin
        got = 1'b1;
        rd = sel ? b1.resp_rdata : b0.resp_rdata;
        f = sel ? b1.resp_fault : b0.resp_fault;
      end
    end
    check("response seen", got, 1);
  endtask
  initial begin
    logic [31:0] rd;
    logic f;
    int lat, k, t, last_t, pulses;
    logic [31:0] addrs [4];
    addrs = '{32'h100, 32'h0, 32'h10, 32'h14};
    b0.req_valid = 1'b0;
    b0.req_write = 1'b0;
    b0.req_addr = '0;
    b0.req_wdata = '0;
    b0.req_width = '0;
    b0.req_sign_extend = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    xact(0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, rd, f, lat);
    check("store word latency", lat, 2);
    check("store word fault", f, 0);
    xact(0, 0, 32'h100, 0, 2'b10, 0, rd, f, lat);
    check("load word", rd, 32'hDEADBEEF);
    check("load word latency", lat, 2);
    xact(0, 1, 32'h0, 32'h000080FF, 2'b10, 0, rd, f, lat);
    xact(0, 0, 32'h0, 0, 2'b00, 1, rd, f, lat);
    check("lb sext @0", rd, 32'hFFFFFFFF);
    xact(0, 0, 32'h0, 0, 2'b01, 0, rd, f, lat);
    check("lhu @0", rd, 32'h000080FF);
    xact(0, 0, 32'h1, 0, 2'b00, 1, rd, f, lat);
    check("lb sext @1", rd, 32'hFFFFFF80);
    xact(0, 1, 32'h10, 32'h44332211, 2'b10, 0, rd, f, lat);
    xact(0, 1, 32'h14, 32'h88776655, 2'b10, 0, rd, f, lat);
    xact(0, 0, 32'h13, 0, 2'b10, 0, rd, f, lat);
    check("split load", rd, 32'h77665544);
    check("split load latency", lat, 3);
    xact(0, 1, 32'h17, 32'h0000BEEF, 2'b01, 0, rd, f, lat);
    check("split store latency", lat, 3);
    xact(0, 0, 32'h14, 0, 2'b10, 0, rd, f, lat);
    check("split store word 0x14", rd, 32'hEF776655);
    xact(0, 0, 32'h18, 0, 2'b00, 0, rd, f, lat);
    check("split store byte 0x18", rd, 32'h000000BE);
    xact(0, 1, 32'hFFC, 32'h0BADF00D, 2'b10, 0, rd, f, lat);
    xact(0, 1, 32'hFFE, 32'h12345678, 2'b10, 0, rd, f, lat);
    check("range fault", f, 1);
    check("range fault rdata", rd, 0);
    check("range fault latency", lat, 2);
    xact(0, 0, 32'hFFC, 0, 2'b10, 0, rd, f, lat);
    check("last word kept", rd, 32'h0BADF00D);
    xact(0, 0, 32'h0, 0, 2'b10, 0, rd, f, lat);
    check("no wrap to word 0", rd, 32'h000080FF);
    xact(0, 0, 32'hFFF, 0, 2'b00, 0, rd, f, lat);
    check("last byte in range", rd, 32'h0000000B);
    xact(0, 1, 32'h100, 32'h0, 2'b11, 0, rd, f, lat);
    check("width11 store fault", f, 1);
    xact(0, 0, 32'h100, 0, 2'b11, 1, rd, f, lat);
    check("width11 load fault", f, 1);
    check("width11 load rdata", rd, 0);
    xact(0, 0, 32'h100, 0, 2'b10, 0, rd, f, lat);
    check("word after width11", rd, 32'hDEADBEEF);
    xact(1, 1, 32'h20, 32'hAABBCCDD, 2'b10, 0, rd, f, lat);
    check("trap aligned store", f, 0);
    xact(1, 1, 32'h23, 32'h00005566, 2'b01, 0, rd, f, lat);
    check("trap half @3", f, 1);
    xact(1, 0, 32'h20, 0, 2'b10, 0, rd, f, lat);
    check("trap memory unchanged", rd, 32'hAABBCCDD);
    xact(1, 0, 32'h22, 0, 2'b01, 0, rd, f, lat);
    check("trap aligned half", rd, 32'h0000AABB);
    xact(1, 0, 32'h21, 0, 2'b01, 1, rd, f, lat);
    check("trap load fault", f, 1);
    check("trap load rdata", rd, 0);
    @(posedge clk);
    #1;
    b0.req_write = 1'b0;
    b0.req_width = 2'b10;
    b0.req_sign_extend = 1'b0;
    b0.req_addr = addrs[0];
    b0.req_valid = 1'b1;
    k = 0;
    t = 0;
    last_t = 0;
    while (k < 4 && t < 40) begin
      @(negedge clk);
      t++;
      if (b0.req_ready) begin
        if (k > 0) check("stream gap", t - last_t, 2);
        last_t = t;
        k++;
        @(posedge clk);
        #1;
        if (k < 4) b0.req_addr = addrs[k];
        else b0.req_valid = 1'b0;
      end
    end
    check("stream accepts", k, 4);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    b0.req_addr = 32'h13;
    b0.req_valid = 1'b1;
    @(negedge clk);
    check("split accept ready", b0.req_ready, 1);
    @(posedge clk);
    #1 b0.req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready after reset", b0.req_ready, 1);
    pulses = 0;
    repeat (5) begin
      if (b0.resp_valid) pulses++;
      @(negedge clk);
    end
    check("no resp after reset", pulses, 0);
    xact(0, 0, 32'h10, 0, 2'b10, 0, rd, f, lat);
    check("load after reset", rd, 32'h44332211);
    check("load after reset latency", lat, 2);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, handshaked data memory for the RISC-V core's load/store path, the next generation of our fixed 4 KiB combinational data memory. A single-port synchronous word array sits behind a valid/ready request port and a one-cycle response pulse. Misaligned accesses that span two words are split into two sequential beats, or trapped, depending on mode. Out-of-range addresses raise a fault instead of wrapping.

## Interface
- DEPTH_BITS, 10, log2 of word count (10 → 1024 words, 4 KiB).
- MISALIGN_MODE, 0, 0: split word-crossing accesses into two beats; 1: fault on any access not naturally aligned to its size.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified (bits [8·size-1:0] used).
- req_width  input  2  ins[13:12]: 00 byte, 01 half, 10 word, 11 illegal.
- req_sign_extend  input  1  sign-extend sub-word load results.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and faults.
- resp_fault  output  1  valid with resp_valid; request rejected, no memory change.

## Operation
- Handshake: request accepted on a rising edge where req_valid && req_ready. Request fields are sampled only then and held internally. Requester may drop or change them afterwards.
- One outstanding request. No response backpressure; requester must capture resp_* in the pulse cycle.
- Size: 1, 2 or 4 bytes. Byte span is addr .. addr+size-1. Little-endian: lower address maps to lower bits.
- Fault checks are evaluated at accept. Any one of these faults the request:
  - width == 11;
  - addr+size-1 ≥ 4·2^DEPTH_BITS (no wrap-around, unlike the previous generation);
  - MISALIGN_MODE=1 and addr not a multiple of size.
- Single-word access (span inside one word): one beat. Store uses per-byte write enables with no read-modify-write. Load reads the word, then shifts by addr[1:0].
- Split access (span crosses a word boundary, MISALIGN_MODE=0 only):
  - beat 0 covers word addr[31:2], bytes addr[1:0]..3;
  - beat 1 covers word addr[31:2]+1, bytes 0..(addr[1:0]+size-5).
  - Load: beat-0 bytes are latched, then concatenated with beat-1 bytes.
- Load result: width 10 passes all 32 bits. Width 01/00 zero-extends from bit 15/7, or sign-extends when req_sign_extend=1.
- FSM states:
  - IDLE (ready=1): accept → FAULT, BEAT0_LAST, or BEAT0_SPLIT.
  - BEAT0_LAST (ready=0): array access → RESP.
  - BEAT0_SPLIT (ready=0): array access → BEAT1.
  - BEAT1 (ready=0): array access → RESP.
  - FAULT (ready=0) → RESP with fault.
  - RESP (resp_valid=1, ready=1): accept → as from IDLE; else → IDLE.
- Memory contents are not initialised or reset.

## Timing
- Request accepted at edge E0.
- Single-word access: array accessed at E1; resp_valid in the cycle after E1; store committed at E1.
- Split access: beat 0 at E1, beat 1 at E2; resp_valid in the cycle after E2. Both store halves are committed by E2.
- Fault: resp_valid in the cycle after E1 with resp_fault=1; no array write.
- Back-to-back: a request accepted in the RESP cycle has its beat 0 on the next edge. Peak throughput is 1 request / 2 cycles, or 1 / 3 for split accesses.
- Reset (asynchronous assert, any state):
  - state goes to IDLE;
  - resp_valid=0, resp_fault=0, resp_rdata=0;
  - req_ready=0 while rst=1, then 1 from the first cycle after deassertion.
- Reset mid-split store: beat 0 may already be committed; beat 1 is dropped; no response is issued.

## Test plan
- Aligned word: store 0xDEADBEEF @0x100, then load width 10 @0x100 → resp after 1 cycle each, rdata 0xDEADBEEF, fault 0.
- Sub-word extend: word @0x0 = 0x000080FF. Load byte @0x0 with sign=1 → 0xFFFFFFFF. Load half @0x0 with sign=0 → 0x000080FF. Load byte @0x1 with sign=1 → 0xFFFFFF80.
- Split (MISALIGN_MODE=0): words @0x10=0x44332211, @0x14=0x88776655. Load word @0x13 → 0x77665544, resp after 2 cycles. Store half 0xBEEF @0x17 → word @0x14 = 0xEF776655, word @0x18 byte0 = 0xBE.
- Faults: word @0xFFE with DEPTH_BITS=10 → fault, no wrap to word 0. Width 11 → fault. MISALIGN_MODE=1, half @0x3 → fault. For each: rdata 0, memory unchanged.
- Handshake: hold req_valid high with a stream of 4 aligned loads → one accepted every 2 cycles, no request lost or repeated, responses in order.
- Reset during BEAT1 of a split load → no resp_valid pulse; req_ready rises the cycle after rst deasserts; the next load completes normally.
